// File: rtl/sram_arbiter.sv
// Two-port arbiter and strobe sequencer for an external asynchronous SRAM.
// Port A (CPU data, read/write) and port B (instruction fetch, read-only) share one bus.
`timescale 1ns/1ps

module sram_arbiter #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 18,
    parameter int WAIT_CYCLES = 1,
    parameter int RR_MODE     = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_ack,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_ack,
    output logic              busy,
    inout  wire  [DATA_W-1:0] dataBus,
    output logic [ADDR_W-1:0] addrBus,
    output logic              memRead,
    output logic              memWrite,
    output logic              memEnable
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                port_b_q, port_b_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                last_b_q, last_b_d;
    logic [ADDR_W-1:0]   addr_bus_q, addr_bus_d;
    logic                mem_en_n_q, mem_en_n_d;
    logic                mem_rd_n_q, mem_rd_n_d;
    logic                mem_wr_n_q, mem_wr_n_d;
    logic                drive_q, drive_d;
    logic                a_ack_q, a_ack_d;
    logic                b_ack_q, b_ack_d;
    logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;
    logic                busy_q, busy_d;
    logic                grant_b_s;

    // Arbitration: B wins alone, or on a tie in round-robin mode when A was granted last.
    always_comb begin
        grant_b_s = 1'b0;
        if (b_req && !a_req) begin
            grant_b_s = 1'b1;
        end else if (a_req && b_req && (RR_MODE != 32'sd0) && !last_b_q) begin
            grant_b_s = 1'b1;
        end else begin
            grant_b_s = 1'b0;
        end
    end

    // Next-state and next-output logic; every pin value is computed one cycle ahead and registered.
    always_comb begin
        state_d    = state_q;
        port_b_d   = port_b_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        last_b_d   = last_b_q;
        addr_bus_d = addr_bus_q;
        mem_en_n_d = 1'b1;
        mem_rd_n_d = 1'b1;
        mem_wr_n_d = 1'b1;
        drive_d    = 1'b0;
        a_ack_d    = 1'b0;
        b_ack_d    = 1'b0;
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (a_req || b_req) begin
                    state_d    = ST_SETUP;
                    port_b_d   = grant_b_s;
                    last_b_d   = grant_b_s;
                    we_d       = grant_b_s ? 1'b0 : a_we;
                    wdata_d    = a_wdata;
                    addr_bus_d = grant_b_s ? b_addr : a_addr;
                    mem_en_n_d = 1'b0;
                    mem_rd_n_d = we_d;
                    drive_d    = we_d;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_d    = ST_ACCESS;
                cnt_d      = CNT_W'(WAIT_CYCLES - 1);
                mem_en_n_d = 1'b0;
                mem_rd_n_d = we_q;
                mem_wr_n_d = ~we_q;
                drive_d    = we_q;
            end
            ST_ACCESS: begin
                mem_en_n_d = 1'b0;
                drive_d    = we_q;
                if (cnt_q == {CNT_W{1'b0}}) begin
                    // Strobes release here; address and write data stay put through DONE.
                    state_d = ST_DONE;
                    if (port_b_q) begin
                        b_ack_d   = 1'b1;
                        b_rdata_d = dataBus;
                    end else begin
                        a_ack_d = 1'b1;
                        if (!we_q) begin
                            a_rdata_d = dataBus;
                        end else begin
                            a_rdata_d = a_rdata_q;
                        end
                    end
                end else begin
                    cnt_d      = cnt_q - CNT_W'(1);
                    mem_rd_n_d = we_q;
                    mem_wr_n_d = ~we_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            port_b_q   <= 1'b0;
            we_q       <= 1'b0;
            wdata_q    <= {DATA_W{1'b0}};
            cnt_q      <= {CNT_W{1'b0}};
            last_b_q   <= 1'b1;
            addr_bus_q <= {ADDR_W{1'b0}};
            mem_en_n_q <= 1'b1;
            mem_rd_n_q <= 1'b1;
            mem_wr_n_q <= 1'b1;
            drive_q    <= 1'b0;
            a_ack_q    <= 1'b0;
            b_ack_q    <= 1'b0;
            a_rdata_q  <= {DATA_W{1'b0}};
            b_rdata_q  <= {DATA_W{1'b0}};
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            port_b_q   <= port_b_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            last_b_q   <= last_b_d;
            addr_bus_q <= addr_bus_d;
            mem_en_n_q <= mem_en_n_d;
            mem_rd_n_q <= mem_rd_n_d;
            mem_wr_n_q <= mem_wr_n_d;
            drive_q    <= drive_d;
            a_ack_q    <= a_ack_d;
            b_ack_q    <= b_ack_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
            busy_q     <= busy_d;
        end
    end

    assign dataBus   = drive_q ? wdata_q : {DATA_W{1'bz}};
    assign addrBus   = addr_bus_q;
    assign memEnable = mem_en_n_q;
    assign memRead   = mem_rd_n_q;
    assign memWrite  = mem_wr_n_q;
    assign a_ack     = a_ack_q;
    assign b_ack     = b_ack_q;
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: two instances (W=1 fixed priority, W=3 round-robin) on async SRAM models,
// checked every cycle against a transaction-level model of the access timeline.
`timescale 1ns/1ps

module tb_sram_arbiter;
    localparam int DW = 16;
    localparam int AW = 18;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    logic clk = 1'b0;
    logic rst;
    logic load_mem;
    always #5 clk = ~clk;

    logic          a_req [2];
    logic          a_we [2];
    logic [AW-1:0] a_addr [2];
    logic [DW-1:0] a_wdata [2];
    logic          b_req [2];
    logic [AW-1:0] b_addr [2];
    logic [DW-1:0] a_rdata_w [2];
    logic [DW-1:0] b_rdata_w [2];
    logic          a_ack_w [2];
    logic          b_ack_w [2];
    logic          busy_w [2];
    logic [AW-1:0] addr_w [2];
    logic          rd_w [2];
    logic          wr_w [2];
    logic          en_w [2];
    wire  [DW-1:0] bus0;
    wire  [DW-1:0] bus1;
    logic [DW-1:0] sram0 [256];
    logic [DW-1:0] sram1 [256];

    sram_arbiter #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(1), .RR_MODE(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .a_req(a_req[0]), .a_we(a_we[0]), .a_addr(a_addr[0]), .a_wdata(a_wdata[0]),
        .a_rdata(a_rdata_w[0]), .a_ack(a_ack_w[0]),
        .b_req(b_req[0]), .b_addr(b_addr[0]), .b_rdata(b_rdata_w[0]), .b_ack(b_ack_w[0]),
        .busy(busy_w[0]), .dataBus(bus0), .addrBus(addr_w[0]),
        .memRead(rd_w[0]), .memWrite(wr_w[0]), .memEnable(en_w[0])
    );

    sram_arbiter #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(3), .RR_MODE(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .a_req(a_req[1]), .a_we(a_we[1]), .a_addr(a_addr[1]), .a_wdata(a_wdata[1]),
        .a_rdata(a_rdata_w[1]), .a_ack(a_ack_w[1]),
        .b_req(b_req[1]), .b_addr(b_addr[1]), .b_rdata(b_rdata_w[1]), .b_ack(b_ack_w[1]),
        .busy(busy_w[1]), .dataBus(bus1), .addrBus(addr_w[1]),
        .memRead(rd_w[1]), .memWrite(wr_w[1]), .memEnable(en_w[1])
    );

    function automatic logic [DW-1:0] pat(int i);
        if (i == 32'h20) return 16'hBEEF;
        if (i == 32'h30) return 16'hC0DE;
        return 16'(i * 257) ^ 16'h3C5A;
    endfunction

    // Async SRAM devices: output when CE and OE low, store while CE and WE low.
    assign bus0 = (!en_w[0] && !rd_w[0]) ? sram0[addr_w[0][7:0]] : {DW{1'bz}};
    assign bus1 = (!en_w[1] && !rd_w[1]) ? sram1[addr_w[1][7:0]] : {DW{1'bz}};

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 256; i++) sram0[i] <= pat(i);
        end else if (!en_w[0] && !wr_w[0]) begin
            sram0[addr_w[0][7:0]] <= bus0;
        end
    end

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 256; i++) sram1[i] <= pat(i);
        end else if (!en_w[1] && !wr_w[1]) begin
            sram1[addr_w[1][7:0]] <= bus1;
        end
    end

    // Reference model state
    bit            act [2];
    int            g [2];
    bit            tport [2];
    req_t          treq [2];
    logic [AW-1:0] e_addr [2];
    logic [DW-1:0] e_ard [2];
    logic [DW-1:0] e_brd [2];
    bit            last_b [2];
    logic [DW-1:0] ref_mem [2][256];
    req_t          qa [2][64];
    req_t          qb [2][64];
    int            ha [2], ta [2], hb [2], tb_ [2];
    int            cyc, total, bad;
    int            n_wr_low [2], n_aack [2], n_back [2], aack_cyc [2];
    logic [DW-1:0] aack_rd [2], back_rd [2];
    logic [7:0]    seq [2];

    function automatic int wk(int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic chk(string nm, int k, logic [31:0] act_v, logic [31:0] exp_v);
        total++;
        if (act_v !== exp_v) begin
            bad++;
            $display("FAIL %s inst%0d cyc=%0d actual=%h required=%h", nm, k, cyc, act_v, exp_v);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            act[k] = 1'b0; e_addr[k] = '0; e_ard[k] = '0; e_brd[k] = '0; last_b[k] = 1'b1;
            ha[k] = 0; ta[k] = 0; hb[k] = 0; tb_[k] = 0;
            a_req[k] = 1'b0; b_req[k] = 1'b0;
        end
    endtask

    task automatic clear_obs();
        for (int k = 0; k < 2; k++) begin
            n_wr_low[k] = 0; n_aack[k] = 0; n_back[k] = 0; aack_cyc[k] = -1;
            aack_rd[k] = '0; back_rd[k] = '0; seq[k] = 8'h00;
        end
    endtask

    task automatic push_a(int k, logic we, logic [AW-1:0] addr, logic [DW-1:0] wd);
        qa[k][ta[k] % 64] = '{we: we, addr: addr, wdata: wd};
        ta[k]++;
    endtask

    task automatic push_b(int k, logic [AW-1:0] addr);
        qb[k][tb_[k] % 64] = '{we: 1'b0, addr: addr, wdata: 16'h0000};
        tb_[k]++;
    endtask

    task automatic rst_lit(int k);
        logic [DW-1:0] bv;
        bv = (k == 0) ? bus0 : bus1;
        chk("rst_memEnable", k, 32'(en_w[k]), 32'd1);
        chk("rst_memRead", k, 32'(rd_w[k]), 32'd1);
        chk("rst_memWrite", k, 32'(wr_w[k]), 32'd1);
        chk("rst_addrBus", k, 32'(addr_w[k]), 32'd0);
        chk("rst_busy", k, 32'(busy_w[k]), 32'd0);
        chk("rst_acks", k, 32'({a_ack_w[k], b_ack_w[k]}), 32'd0);
        chk("rst_bus_released", k, 32'(bv == 16'h5A5A), 32'd0);
    endtask

    // One cycle: compare DUT against the model, then update requesters and model grants.
    task automatic step();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            int t; int w; bit ea; bit eb; bit ebusy; bit een; bit erd; bit ewr;
            logic [DW-1:0] bv; req_t h;
            w = wk(k); ea = 1'b0; eb = 1'b0; ebusy = 1'b0; een = 1'b1; erd = 1'b1; ewr = 1'b1;
            bv = (k == 0) ? bus0 : bus1;
            if (act[k]) begin
                t = cyc - g[k];
                if (t <= w + 1) begin
                    ebusy = 1'b1; een = 1'b0; e_addr[k] = treq[k].addr;
                    if (!treq[k].we && t <= w) erd = 1'b0;
                    if (treq[k].we && t >= 1 && t <= w) ewr = 1'b0;
                    if (treq[k].we) chk("bus_wdata", k, 32'(bv), 32'(treq[k].wdata));
                    if (t == w + 1) begin
                        if (tport[k]) begin
                            eb = 1'b1; e_brd[k] = ref_mem[k][treq[k].addr[7:0]];
                        end else begin
                            ea = 1'b1;
                            if (treq[k].we) ref_mem[k][treq[k].addr[7:0]] = treq[k].wdata;
                            else e_ard[k] = ref_mem[k][treq[k].addr[7:0]];
                        end
                    end
                end else begin
                    act[k] = 1'b0;
                end
            end
            chk("busy", k, 32'(busy_w[k]), 32'(ebusy));
            chk("memEnable", k, 32'(en_w[k]), 32'(een));
            chk("memRead", k, 32'(rd_w[k]), 32'(erd));
            chk("memWrite", k, 32'(wr_w[k]), 32'(ewr));
            chk("a_ack", k, 32'(a_ack_w[k]), 32'(ea));
            chk("b_ack", k, 32'(b_ack_w[k]), 32'(eb));
            chk("addrBus", k, 32'(addr_w[k]), 32'(e_addr[k]));
            chk("a_rdata", k, 32'(a_rdata_w[k]), 32'(e_ard[k]));
            chk("b_rdata", k, 32'(b_rdata_w[k]), 32'(e_brd[k]));
            if (!wr_w[k]) n_wr_low[k]++;
            if (a_ack_w[k]) begin
                n_aack[k]++; aack_cyc[k] = cyc; aack_rd[k] = a_rdata_w[k]; seq[k] = {seq[k][6:0], 1'b0};
            end
            if (b_ack_w[k]) begin
                n_back[k]++; back_rd[k] = b_rdata_w[k]; seq[k] = {seq[k][6:0], 1'b1};
            end
            if (ea) ha[k]++;
            if (eb) hb[k]++;
            a_req[k] = (ha[k] != ta[k]);
            if (a_req[k]) begin
                h = qa[k][ha[k] % 64];
                a_we[k] = h.we; a_addr[k] = h.addr; a_wdata[k] = h.wdata;
            end
            b_req[k] = (hb[k] != tb_[k]);
            if (b_req[k]) begin
                h = qb[k][hb[k] % 64];
                b_addr[k] = h.addr;
            end
            if (rst && !act[k] && (a_req[k] || b_req[k])) begin
                bit gb;
                gb = b_req[k] && (!a_req[k] || (k == 1 && !last_b[k]));
                act[k] = 1'b1; g[k] = cyc + 1; tport[k] = gb; last_b[k] = gb;
                treq[k] = gb ? '{we: 1'b0, addr: b_addr[k], wdata: 16'h0000} : qa[k][ha[k] % 64];
            end
        end
        cyc++;
    endtask

    task automatic drain(int budget);
        int n;
        n = 0;
        while ((act[0] || act[1] || ha[0] != ta[0] || hb[0] != tb_[0] || ha[1] != ta[1] || hb[1] != tb_[1])
               && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            total++; bad++;
            $display("FAIL drain_timeout cyc=%0d actual=busy required=idle", cyc);
        end
    endtask

    initial begin
        int p;
        rst = 1'b0; load_mem = 1'b1; cyc = 0; total = 0; bad = 0;
        model_reset();
        clear_obs();
        for (int k = 0; k < 2; k++) begin
            a_we[k] = 1'b0; a_addr[k] = '0; a_wdata[k] = '0; b_addr[k] = '0;
            for (int i = 0; i < 256; i++) ref_mem[k][i] = pat(i);
        end
        repeat (3) step();
        for (int k = 0; k < 2; k++) rst_lit(k);
        load_mem = 1'b0;
        rst = 1'b1;

        // Write then read back on port A
        clear_obs();
        p = cyc;
        for (int k = 0; k < 2; k++) begin
            push_a(k, 1'b1, 18'h00010, 16'h1234);
            push_a(k, 1'b0, 18'h00010, 16'h0000);
        end
        drain(100);
        for (int k = 0; k < 2; k++) begin
            chk("rd_ack_cycle", k, 32'(aack_cyc[k]), 32'(p + ((k == 0) ? 7 : 11)));
            chk("rd_data_1234", k, 32'(aack_rd[k]), 32'h1234);
            chk("a_ack_count", k, 32'(n_aack[k]), 32'd2);
            chk("we_low_cycles", k, 32'(n_wr_low[k]), 32'((k == 0) ? 1 : 3));
        end

        // Single fetch on port B
        clear_obs();
        for (int k = 0; k < 2; k++) push_b(k, 18'h00020);
        drain(100);
        for (int k = 0; k < 2; k++) begin
            chk("b_data_beef", k, 32'(back_rd[k]), 32'hBEEF);
            chk("b_ack_count", k, 32'(n_back[k]), 32'd1);
            chk("a_ack_quiet", k, 32'(n_aack[k]), 32'd0);
        end

        // Simultaneous held requests: fixed priority vs round-robin
        clear_obs();
        for (int k = 0; k < 2; k++) begin
            push_a(k, 1'b0, 18'h00001, 16'h0000);
            push_a(k, 1'b0, 18'h00002, 16'h0000);
            push_a(k, 1'b0, 18'h00003, 16'h0000);
            push_b(k, 18'h00004);
            push_b(k, 18'h00005);
        end
        drain(200);
        chk("grant_order_fixed", 0, 32'(seq[0][4:0]), 32'h03);
        chk("grant_order_rr", 1, 32'(seq[1][4:0]), 32'h0A);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            for (int k = 0; k < 2; k++) begin
                if (ta[k] - ha[k] < 2 && $urandom_range(0, 2) == 0)
                    push_a(k, 1'($urandom), {10'($urandom), 8'($urandom_range(64, 255))}, 16'($urandom));
                if (tb_[k] - hb[k] < 2 && $urandom_range(0, 2) == 0)
                    push_b(k, {10'($urandom), 8'($urandom_range(64, 255))});
            end
            step();
        end
        drain(200);

        // Reset in the middle of a write access
        for (int k = 0; k < 2; k++) push_a(k, 1'b1, 18'h00040, 16'h5A5A);
        repeat (3) step();
        #2 rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) rst_lit(k);
        model_reset();
        clear_obs();
        repeat (2) step();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) push_b(k, 18'h00030);
        drain(100);
        for (int k = 0; k < 2; k++) begin
            chk("post_rst_b_data", k, 32'(back_rd[k]), 32'hC0DE);
            chk("post_rst_no_a_ack", k, 32'(n_aack[k]), 32'd0);
            chk("post_rst_b_count", k, 32'(n_back[k]), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
